// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache, one 32-bit word per line.
// Define ICACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module icache_dm #(
    parameter  int SETS = 16,
    localparam int IDXW = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAGW = 30 - IDXW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            r_state;
    logic [31:0]       r_miss_addr;
    logic [SETS-1:0]   r_valid;
    logic [TAGW-1:0]   r_tag  [SETS];
    logic [31:0]       r_data [SETS];

    logic [IDXW-1:0]   w_idx;
    logic [IDXW-1:0]   w_fill_idx;
    logic [TAGW-1:0]   w_tag;
    logic [TAGW-1:0]   w_fill_tag;
    logic              w_lookup;
    logic              w_miss;
    logic              w_fill_done;
    logic              w_unused;

    assign w_idx       = imemaddr[IDXW+1:2];
    assign w_tag       = imemaddr[31:IDXW+2];
    assign w_fill_idx  = r_miss_addr[IDXW+1:2];
    assign w_fill_tag  = r_miss_addr[31:IDXW+2];
    assign w_unused    = ^imemaddr[1:0];

    assign w_lookup    = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss      = (r_state == IDLE) & imemREN & ~w_lookup & ~flush;
    assign w_fill_done = (r_state == FETCH) & ~iwait;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        if (r_state == IDLE) begin
            ihit = w_lookup & ~flush;
            if (ihit) imemload = r_data[w_idx];
        end else begin
            iREN  = 1'b1;
            iaddr = r_miss_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the later r_valid write
    // (fill) overrides the flush clear on the same edge, which is the intended priority.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_valid     <= '0;
        end else begin
            if (flush) r_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_miss_addr <= {imemaddr[31:2], 2'b00};
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: tag/data arrays are cleared on reset so the cache powers up in a known state;
    // the valid bits alone would suffice for correctness.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_fill_done) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (ihit && (r_hit_cnt != 32'hFFFF_FFFF))   r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized scoreboard bench for icache_dm against a word-level cache model.
// Build with ICACHE_STATS_EN defined to also check the hit/miss counters.
module tb_icache_dm;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
    logic        flush = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_dm #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .flush    (flush)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } fill_t;

    exp_t  exp_q[$];
    fill_t fill_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which word address each line currently holds.
    logic [31:0] line_addr [SETS];
    bit          line_ok   [SETS];
    int          m_hits = 0;
    int          m_misses = 0;

    int next_lat = 0;
    int cur_lat = 0;
    int fcnt = 0;
    int m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_0040) return 32'h2408_0001;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit cached(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return line_ok[idx_of(w)] && (line_addr[idx_of(w)] == w);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < SETS; i++) line_ok[i] = 1'b0;
    endfunction

    function automatic void model_install(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        line_ok[idx_of(w)]   = 1'b1;
        line_addr[idx_of(w)] = w;
    endfunction

    // Memory: holds iwait high for cur_lat cycles of each fill, then returns the word.
    always @(negedge CLK) begin
        if (iREN) begin
            iwait = (fcnt < cur_lat);
            iload = iwait ? 32'hDEAD_BEEF : mem_word(iaddr);
            fcnt++;
        end else begin
            iwait   = 1'b1;
            iload   = '0;
            fcnt    = 0;
            cur_lat = next_lat;
        end
    end

    // Monitor: pops fills on each iREN burst and expected words on each ihit.
    bit    in_fill = 1'b0;
    int    f_cnt = 0;
    fill_t cur_fill;
    always @(negedge CLK) begin
        exp_t e;
        if (!nRST) begin
            in_fill = 1'b0;
            m_cnt   = 0;
        end else begin
            if (iREN) begin
                if (!in_fill) begin
                    if (fill_q.size() == 0) begin
                        check("unexpected_fill_iREN", {31'b0, iREN}, 32'd0);
                        cur_fill.addr = iaddr;
                        cur_fill.len  = -1;
                    end else begin
                        cur_fill = fill_q.pop_front();
                    end
                    in_fill = 1'b1;
                    f_cnt   = 0;
                end
                check("fill_iaddr", iaddr, cur_fill.addr);
                f_cnt++;
            end else if (in_fill) begin
                check("fill_len", f_cnt, cur_fill.len);
                check("iaddr_zero_when_idle", iaddr, 32'd0);
                in_fill = 1'b0;
            end

            if (exp_q.size() > 0) begin
                if (ihit) begin
                    e = exp_q.pop_front();
                    check("hit_data", imemload, e.data);
                    check("hit_cycle", m_cnt, e.cyc);
                    m_cnt = 0;
                end else begin
                    check("load_zero_no_hit", imemload, 32'd0);
                    m_cnt++;
                end
            end else begin
                check("no_unexpected_hit", {31'b0, ihit}, 32'd0);
                check("load_zero_idle", imemload, 32'd0);
            end
        end
    end

    // Issue one fetch; base = cycles the cache is busy before it can look at this address.
    task automatic fetch(input logic [31:0] a, input int lat, input int flush_at, input int base);
        exp_t e;
        bit   hit;
        bit   done;
        hit    = cached(a);
        e.data = mem_word(a);
        e.cyc  = base + (hit ? 0 : lat + 2);
        if (!hit) begin
            fill_q.push_back('{a & 32'hFFFF_FFFC, lat + 1});
            next_lat = lat;
            m_misses++;
            if (flush_at >= 0) model_clear();
            model_install(a);
        end else begin
            flush_at = -1;
        end
        m_hits++;
        exp_q.push_back(e);
        imemREN  = 1'b1;
        imemaddr = a;
        done     = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (ihit) begin
                done = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
            flush = (c == flush_at);
        end
        if (!done) begin
            check("hit_timeout", {31'b0, ihit}, 32'd1);
            exp_q.delete();
            fill_q.delete();
            m_cnt = 0;
        end
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic flush_idle(input logic [31:0] a);
        imemREN  = 1'b1;
        imemaddr = a;
        flush    = 1'b1;
        @(posedge CLK);
        #1;
        flush   = 1'b0;
        imemREN = 1'b0;
        model_clear();
    endtask

    // Miss on a, then move the fetch address to b one cycle into the fill.
    task automatic redirect(input logic [31:0] a, input logic [31:0] b, input int lat_a, input int lat_b);
        fill_q.push_back('{a & 32'hFFFF_FFFC, lat_a + 1});
        next_lat = lat_a;
        m_misses++;
        imemREN  = 1'b1;
        imemaddr = a;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        model_install(a);
        fetch(b, lat_b, -1, lat_a);
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hit_cnt"}, hit_cnt, m_hits);
        check({tag, "_miss_cnt"}, miss_cnt, m_misses);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, SETS - 1) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) a = a | 32'h0040_0000;
        return a;
    endfunction

    initial begin
        model_clear();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ihit", {31'b0, ihit}, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iREN", {31'b0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Cold miss, then warm hit.
        fetch(32'h0000_0040, 2, -1, 0);
        fetch(32'h0000_0040, 0, -1, 0);
        check_stats("cold_warm");

        // Flush in IDLE with 0x40 presented, then three conflicting misses on index 0.
        flush_idle(32'h0000_0040);
        fetch(32'h0000_0040, 1, -1, 0);
        fetch(32'h0000_0080, 1, -1, 0);
        fetch(32'h0000_0040, 1, -1, 0);

        // Redirect: 0x100 and 0x200 share index 0, so the later 0x100 is a conflict miss.
        redirect(32'h0000_0100, 32'h0000_0200, 2, 1);
        fetch(32'h0000_0100, 0, -1, 0);
        fetch(32'h0000_0100, 0, -1, 0);

        // Flush during the fill; the filled line must still hit.
        fetch(32'h0000_0344, 3, 1, 0);
        fetch(32'h0000_0344, 0, -1, 0);
        fetch(32'h0000_0100, 1, -1, 0);
        check_stats("directed");

        // Reset in the middle of a fill.
        fill_q.push_back('{32'h0000_0500, 6});
        next_lat = 5;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0500;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("rst_mid_fill_iREN", {31'b0, iREN}, 32'd0);
        check("rst_mid_fill_iaddr", iaddr, 32'd0);
        imemREN = 1'b0;
        fill_q.delete();
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        check_stats("after_reset");
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        fetch(32'h0000_0344, 1, -1, 0);
        fetch(32'h0000_0100, 0, -1, 0);
        fetch(32'h0000_0344, 0, -1, 0);

        for (int t = 0; t < 400; t++) begin
            int          r;
            int          lat;
            logic [31:0] a;
            logic [31:0] b;
            r = $urandom_range(0, 99);
            a = rand_addr();
            b = rand_addr();
            lat = $urandom_range(0, 3);
            if (r < 5) begin
                flush_idle(a);
            end else if (r < 13) begin
                if (!cached(a) && ((a ^ b) & 32'hFFFF_FFFC) != 0)
                    redirect(a, b, $urandom_range(1, 3), lat);
                else
                    fetch(a, lat, -1, 0);
            end else if (r < 23) begin
                lat = $urandom_range(1, 3);
                fetch(a, lat, $urandom_range(0, lat), 0);
            end else begin
                fetch(a, lat, -1, 0);
            end
        end
        check_stats("final");

        repeat (3) @(posedge CLK);
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("fill_queue_drained", fill_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
